// File: rtl/iexecute.sv
// RISC-V execute stage: ALU, address generation, branch/jump resolution and EX/MEM register.
// Define IEXECUTE_SERIAL_SHIFT_EN for a 1-bit-per-cycle shifter with busy back-pressure.
module iexecute #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            stall,
    input  logic [XLEN-1:0] pc,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] imm,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            reg_write_enable,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            is_branch,
    input  logic            jump,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd_out,
    output logic            reg_write_enable_out,
    output logic            mem_read_out,
    output logic            mem_write_out,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            busy
);
    localparam int SHW = (XLEN == 64) ? 6 : 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    logic [3:0]      w_op;
    logic [XLEN-1:0] w_b, w_alu, w_res, w_tgt, w_jalr_sum;
    logic [SHW-1:0]  w_shamt;
    logic            w_taken, w_bubble;
    logic [XLEN-1:0] w_nx_res, w_nx_st, w_nx_tgt;
    logic [4:0]      w_nx_rd;
    logic            w_nx_we, w_nx_mr, w_nx_mw, w_nx_tk;
    logic            w_unused;

    assign w_unused = ^{funct7[6], funct7[4:0], is_branch, jump};

    always_comb begin
        w_op = ALU_NOP;
        w_b  = rs2_data;
        if (opcode == OPC_OP) begin
            w_op = alu_op;
        end else if (opcode == OPC_IMM) begin
            w_b = imm;
            case (funct3)
                3'b000: w_op = ALU_ADD;
                3'b001: w_op = ALU_SLL;
                3'b010: w_op = ALU_SLT;
                3'b011: w_op = ALU_SLTU;
                3'b100: w_op = ALU_XOR;
                3'b101: w_op = funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110: w_op = ALU_OR;
                3'b111: w_op = ALU_AND;
                default: w_op = ALU_NOP;
            endcase
        end
    end

    assign w_shamt = w_b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (w_op)
            ALU_ADD:  w_alu = rs1_data + w_b;
            ALU_SUB:  w_alu = rs1_data - w_b;
            ALU_AND:  w_alu = rs1_data & w_b;
            ALU_OR:   w_alu = rs1_data | w_b;
            ALU_XOR:  w_alu = rs1_data ^ w_b;
            ALU_SLL:  w_alu = rs1_data << w_shamt;
            ALU_SRL:  w_alu = rs1_data >> w_shamt;
            ALU_SRA:  w_alu = $signed(rs1_data) >>> w_shamt;
            ALU_SLT:  w_alu[0] = $signed(rs1_data) < $signed(w_b);
            ALU_SLTU: w_alu[0] = rs1_data < w_b;
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        case (opcode)
            OPC_OP, OPC_IMM:     w_res = w_alu;
            OPC_LOAD, OPC_STORE: w_res = rs1_data + imm;
            OPC_LUI:             w_res = imm;
            OPC_AUIPC:           w_res = pc + imm;
            OPC_JAL, OPC_JALR:   w_res = pc + XLEN'(4);
            default:             w_res = '0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (opcode)
            OPC_JAL, OPC_JALR: w_taken = 1'b1;
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  w_taken = rs1_data == rs2_data;
                    3'b001:  w_taken = rs1_data != rs2_data;
                    3'b100:  w_taken = $signed(rs1_data) <  $signed(rs2_data);
                    3'b101:  w_taken = $signed(rs1_data) >= $signed(rs2_data);
                    3'b110:  w_taken = rs1_data <  rs2_data;
                    3'b111:  w_taken = rs1_data >= rs2_data;
                    default: w_taken = 1'b0;
                endcase
            end
            default: w_taken = 1'b0;
        endcase
    end

    assign w_jalr_sum = rs1_data + imm;
    assign w_tgt      = (opcode == OPC_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : pc + imm;

`ifdef IEXECUTE_SERIAL_SHIFT_EN
    typedef enum logic {S_IDLE, S_SHIFT} state_e;

    state_e          r_state, w_state_nxt;
    logic [XLEN-1:0] r_sh, w_sh_nxt, w_sh1;
    logic [SHW-1:0]  r_cnt, w_cnt_nxt;

    always_comb begin
        case (w_op)
            ALU_SLL: w_sh1 = r_sh << 1;
            ALU_SRA: w_sh1 = {r_sh[XLEN-1], r_sh[XLEN-1:1]};
            default: w_sh1 = r_sh >> 1;
        endcase
    end
`endif

    always_comb begin
        w_nx_res = w_res;
        w_nx_st  = rs2_data;
        w_nx_tgt = w_tgt;
        w_nx_rd  = rd;
        w_nx_we  = reg_write_enable;
        w_nx_mr  = mem_read;
        w_nx_mw  = mem_write;
        w_nx_tk  = w_taken;
        w_bubble = flush;
`ifdef IEXECUTE_SERIAL_SHIFT_EN
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            // Upstream holds its inputs while busy, so the live op/rd/controls
            // still describe the shift being completed.
            case (r_state)
                S_IDLE: begin
                    if ((w_op == ALU_SLL || w_op == ALU_SRL || w_op == ALU_SRA) && w_shamt != '0) begin
                        w_state_nxt = S_SHIFT;
                        w_sh_nxt    = rs1_data;
                        w_cnt_nxt   = w_shamt;
                        w_bubble    = 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == SHW'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_nx_res    = w_sh1;
                    end else begin
                        w_sh_nxt  = w_sh1;
                        w_cnt_nxt = r_cnt - SHW'(1);
                        w_bubble  = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
`endif
        if (w_bubble) begin
            w_nx_res = '0;
            w_nx_st  = '0;
            w_nx_tgt = '0;
            w_nx_rd  = '0;
            w_nx_we  = 1'b0;
            w_nx_mr  = 1'b0;
            w_nx_mw  = 1'b0;
            w_nx_tk  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alu_result           <= '0;
            store_data           <= '0;
            rd_out               <= '0;
            reg_write_enable_out <= 1'b0;
            mem_read_out         <= 1'b0;
            mem_write_out        <= 1'b0;
            branch_taken         <= 1'b0;
            branch_target        <= '0;
        end else if (flush || !stall) begin
            alu_result           <= w_nx_res;
            store_data           <= w_nx_st;
            rd_out               <= w_nx_rd;
            reg_write_enable_out <= w_nx_we;
            mem_read_out         <= w_nx_mr;
            mem_write_out        <= w_nx_mw;
            branch_taken         <= w_nx_tk;
            branch_target        <= w_nx_tgt;
        end
    end

`ifdef IEXECUTE_SERIAL_SHIFT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
        end else if (flush || !stall) begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign busy = (r_state == S_SHIFT);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_iexecute.sv
// Self-checking bench for iexecute: directed vector table, multi-cycle sequences, random vs. model.
module tb_iexecute;
    localparam int XLEN = 64;

    logic        clk = 1'b0;
    logic        resetn, flush, stall;
    logic [63:0] pc, imm, rs1_data, rs2_data;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        reg_write_enable, mem_read, mem_write, is_branch, jump;
    logic [63:0] alu_result, store_data, branch_target;
    logic [4:0]  rd_out;
    logic        reg_write_enable_out, mem_read_out, mem_write_out, branch_taken, busy;

    always #5 clk = ~clk;

    iexecute #(.XLEN(XLEN)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
        .pc(pc), .opcode(opcode), .rd(rd), .funct3(funct3), .funct7(funct7),
        .imm(imm), .alu_op(alu_op), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .reg_write_enable(reg_write_enable), .mem_read(mem_read), .mem_write(mem_write),
        .is_branch(is_branch), .jump(jump),
        .alu_result(alu_result), .store_data(store_data), .rd_out(rd_out),
        .reg_write_enable_out(reg_write_enable_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .branch_taken(branch_taken),
        .branch_target(branch_target), .busy(busy)
    );

    typedef struct {
        logic [63:0] pc; logic [6:0] opc; logic [4:0] rd; logic [2:0] f3; logic [6:0] f7;
        logic [63:0] imm; logic [3:0] aop; logic [63:0] rs1, rs2;
        logic we, mr, mw, br, jp;
    } vin_t;

    typedef struct {
        logic [63:0] res; logic tk; logic [63:0] tgt; logic [4:0] rdo; logic we, mr, mw;
    } vexp_t;

    typedef struct { string name; vin_t vi; vexp_t ve; } vec_t;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vin_t mkv(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [3:0] aop, input logic [63:0] p, input logic [63:0] im,
                                 input logic [63:0] a, input logic [63:0] b, input logic [4:0] d,
                                 input logic we, input logic mr, input logic mw);
        vin_t v;
        v.opc = opc; v.f3 = f3; v.f7 = f7; v.aop = aop; v.pc = p; v.imm = im;
        v.rs1 = a; v.rs2 = b; v.rd = d; v.we = we; v.mr = mr; v.mw = mw;
        v.br = (opc == 7'h63);
        v.jp = (opc == 7'h6f) || (opc == 7'h67);
        return v;
    endfunction

    function automatic vexp_t mke(input logic [63:0] res, input logic tk, input logic [63:0] tgt,
                                  input logic [4:0] d, input logic we, input logic mr, input logic mw);
        vexp_t e;
        e.res = res; e.tk = tk; e.tgt = tgt; e.rdo = d; e.we = we; e.mr = mr; e.mw = mw;
        return e;
    endfunction

    // Reference model: mnemonic number (1..10 as alu_op encodes them) and operand B.
    function automatic int op_of(input vin_t v);
        int t [8] = '{1, 6, 9, 10, 5, 7, 4, 3};
        if (v.opc == 7'h33) return (v.aop <= 4'd10) ? int'(v.aop) : 0;
        if (v.opc == 7'h13) return (v.f3 == 3'd5 && v.f7[5]) ? 8 : t[v.f3];
        return 0;
    endfunction

    function automatic logic [63:0] opb(input vin_t v);
        return (v.opc == 7'h13) ? v.imm : v.rs2;
    endfunction

    function automatic vexp_t model(input vin_t v);
        vexp_t       e;
        logic [63:0] a, b;
        int          sh;
        a = v.rs1;
        b = opb(v);
        sh = int'(b[5:0]);
        e = mke(64'd0, 1'b0, v.pc + v.imm, v.rd, v.we, v.mr, v.mw);
        case (v.opc)
            7'h33, 7'h13: begin
                case (op_of(v))
                    1: e.res = a + b;
                    2: e.res = a - b;
                    3: e.res = a & b;
                    4: e.res = a | b;
                    5: e.res = a ^ b;
                    6: e.res = a << sh;
                    7: e.res = a >> sh;
                    8: e.res = $signed(a) >>> sh;
                    9: e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                    10: e.res = (a < b) ? 64'd1 : 64'd0;
                    default: e.res = 64'd0;
                endcase
            end
            7'h03, 7'h23: e.res = v.rs1 + v.imm;
            7'h37: e.res = v.imm;
            7'h17: e.res = v.pc + v.imm;
            7'h6f: begin e.res = v.pc + 64'd4; e.tk = 1'b1; end
            7'h67: begin e.res = v.pc + 64'd4; e.tk = 1'b1; e.tgt = (v.rs1 + v.imm) & ~64'd1; end
            7'h63: begin
                case (v.f3)
                    3'd0: e.tk = (v.rs1 == v.rs2);
                    3'd1: e.tk = (v.rs1 != v.rs2);
                    3'd4: e.tk = ($signed(v.rs1) <  $signed(v.rs2));
                    3'd5: e.tk = ($signed(v.rs1) >= $signed(v.rs2));
                    3'd6: e.tk = (v.rs1 <  v.rs2);
                    3'd7: e.tk = (v.rs1 >= v.rs2);
                    default: e.tk = 1'b0;
                endcase
            end
            default: e.res = 64'd0;
        endcase
        return e;
    endfunction

    function automatic int exp_lat(input vin_t v);
        int          op;
        logic [63:0] b;
        op = op_of(v);
        b  = opb(v);
`ifdef IEXECUTE_SERIAL_SHIFT_EN
        if (op >= 6 && op <= 8 && b[5:0] != 6'd0) return int'(b[5:0]) + 1;
`endif
        return (op < 0) ? 0 : 1;
    endfunction

    task automatic drive(input vin_t v);
        pc = v.pc; opcode = v.opc; rd = v.rd; funct3 = v.f3; funct7 = v.f7; imm = v.imm;
        alu_op = v.aop; rs1_data = v.rs1; rs2_data = v.rs2;
        reg_write_enable = v.we; mem_read = v.mr; mem_write = v.mw; is_branch = v.br; jump = v.jp;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".res"}, alu_result, 64'd0);
        chk({nm, ".st"}, store_data, 64'd0);
        chk({nm, ".rd"}, 64'(rd_out), 64'd0);
        chk({nm, ".ctl"}, 64'({reg_write_enable_out, mem_read_out, mem_write_out}), 64'd0);
        chk({nm, ".tk"}, 64'(branch_taken), 64'd0);
        chk({nm, ".tgt"}, branch_target, 64'd0);
        chk({nm, ".busy"}, 64'(busy), 64'd0);
    endtask

    // Presents v, waits (bounded) for busy to clear, then checks latency and outputs.
    task automatic issue(input string nm, input vin_t v, input vexp_t e, input int lat);
        int n;
        drive(v);
        @(posedge clk); #1;
        n = 1;
        while (busy === 1'b1 && n < 200) begin
            chk({nm, ".bubble"}, 64'({alu_result, reg_write_enable_out, branch_taken}), 64'd0);
            @(posedge clk); #1;
            n++;
        end
        chk({nm, ".lat"}, 64'(n), 64'(lat));
        chk({nm, ".res"}, alu_result, e.res);
        chk({nm, ".st"}, store_data, v.rs2);
        chk({nm, ".rd"}, 64'(rd_out), 64'(e.rdo));
        chk({nm, ".ctl"}, 64'({reg_write_enable_out, mem_read_out, mem_write_out}),
            64'({e.we, e.mr, e.mw}));
        chk({nm, ".tk"}, 64'(branch_taken), 64'(e.tk));
        if (e.tk) chk({nm, ".tgt"}, branch_target, e.tgt);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [$];
        vin_t        v, nop, sra3;
        logic [6:0]  opl [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h00};
        logic [31:0] t;
        int          k;

        nop  = mkv(7'h33, 3'd0, 7'd0, 4'd0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        sra3 = mkv(7'h33, 3'd5, 7'h20, 4'd8, 64'd0, 64'd0, 64'h8000_0000_0000_0000, 64'd3, 5'd11, 1'b1, 1'b0, 1'b0);

        tbl.push_back('{"add",   mkv(7'h33, 3'd0, 7'h00, 4'd1, 64'd0, 64'd0, 64'd5, 64'd7, 5'd3, 1, 0, 0),
                                 mke(64'd12, 0, 64'd0, 5'd3, 1, 0, 0)});
        tbl.push_back('{"sub",   mkv(7'h33, 3'd0, 7'h20, 4'd2, 64'd0, 64'd0, 64'd0, 64'd1, 5'd4, 1, 0, 0),
                                 mke(ONES, 0, 64'd0, 5'd4, 1, 0, 0)});
        tbl.push_back('{"slt",   mkv(7'h33, 3'd2, 7'h00, 4'd9, 64'd0, 64'd0, ONES, 64'd1, 5'd5, 1, 0, 0),
                                 mke(64'd1, 0, 64'd0, 5'd5, 1, 0, 0)});
        tbl.push_back('{"sltu",  mkv(7'h33, 3'd3, 7'h00, 4'd10, 64'd0, 64'd0, ONES, 64'd1, 5'd5, 1, 0, 0),
                                 mke(64'd0, 0, 64'd0, 5'd5, 1, 0, 0)});
        tbl.push_back('{"beq_t", mkv(7'h63, 3'd0, 7'h00, 4'd0, 64'h100, 64'h20, 64'd9, 64'd9, 5'd0, 0, 0, 0),
                                 mke(64'd0, 1, 64'h120, 5'd0, 0, 0, 0)});
        tbl.push_back('{"beq_n", mkv(7'h63, 3'd0, 7'h00, 4'd0, 64'h100, 64'h20, 64'd9, 64'd8, 5'd0, 0, 0, 0),
                                 mke(64'd0, 0, 64'h120, 5'd0, 0, 0, 0)});
        tbl.push_back('{"jalr",  mkv(7'h67, 3'd0, 7'h00, 4'd0, 64'h200, 64'd2, 64'h1001, 64'd0, 5'd1, 1, 0, 0),
                                 mke(64'h204, 1, 64'h1002, 5'd1, 1, 0, 0)});
        tbl.push_back('{"jal",   mkv(7'h6f, 3'd0, 7'h00, 4'd0, 64'h40, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 5'd1, 1, 0, 0),
                                 mke(64'h44, 1, 64'h38, 5'd1, 1, 0, 0)});
        tbl.push_back('{"lui",   mkv(7'h37, 3'd0, 7'h00, 4'd0, 64'd0, 64'h1234_5000, 64'd0, 64'd0, 5'd6, 1, 0, 0),
                                 mke(64'h1234_5000, 0, 64'd0, 5'd6, 1, 0, 0)});
        tbl.push_back('{"auipc", mkv(7'h17, 3'd0, 7'h00, 4'd0, 64'h1000, 64'h2000, 64'd0, 64'd0, 5'd6, 1, 0, 0),
                                 mke(64'h3000, 0, 64'd0, 5'd6, 1, 0, 0)});
        tbl.push_back('{"load",  mkv(7'h03, 3'd3, 7'h00, 4'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h100, 64'd0, 5'd7, 1, 1, 0),
                                 mke(64'hFC, 0, 64'd0, 5'd7, 1, 1, 0)});
        tbl.push_back('{"store", mkv(7'h23, 3'd3, 7'h00, 4'd0, 64'd0, 64'd8, 64'h200, 64'hAB, 5'd0, 0, 0, 1),
                                 mke(64'h208, 0, 64'd0, 5'd0, 0, 0, 1)});
        tbl.push_back('{"srai0", mkv(7'h13, 3'd5, 7'h20, 4'd0, 64'd0, 64'h400, 64'h8000_0000_0000_0000, 64'd0, 5'd8, 1, 0, 0),
                                 mke(64'h8000_0000_0000_0000, 0, 64'd0, 5'd8, 1, 0, 0)});
        tbl.push_back('{"xori",  mkv(7'h13, 3'd4, 7'h00, 4'd0, 64'd0, 64'hFF, 64'hF0, 64'd0, 5'd8, 1, 0, 0),
                                 mke(64'h0F, 0, 64'd0, 5'd8, 1, 0, 0)});
        tbl.push_back('{"unk",   mkv(7'h7f, 3'd0, 7'h00, 4'd1, 64'd0, 64'd0, 64'd5, 64'd7, 5'd9, 1, 1, 0),
                                 mke(64'd0, 0, 64'd0, 5'd9, 1, 1, 0)});
        tbl.push_back('{"nop",   mkv(7'h33, 3'd0, 7'h00, 4'd0, 64'd0, 64'd0, 64'd5, 64'd7, 5'd10, 1, 0, 0),
                                 mke(64'd0, 0, 64'd0, 5'd10, 1, 0, 0)});
        tbl.push_back('{"bltu",  mkv(7'h63, 3'd6, 7'h00, 4'd0, 64'h80, 64'h10, 64'd1, ONES, 5'd0, 0, 0, 0),
                                 mke(64'd0, 1, 64'h90, 5'd0, 0, 0, 0)});
        tbl.push_back('{"bge",   mkv(7'h63, 3'd5, 7'h00, 4'd0, 64'h80, 64'h10, ONES, 64'd1, 5'd0, 0, 0, 0),
                                 mke(64'd0, 0, 64'h90, 5'd0, 0, 0, 0)});
        tbl.push_back('{"slli4", mkv(7'h13, 3'd1, 7'h00, 4'd0, 64'd0, 64'd4, 64'd1, 64'd0, 5'd12, 1, 0, 0),
                                 mke(64'h10, 0, 64'd0, 5'd12, 1, 0, 0)});
        tbl.push_back('{"sra3",  sra3, mke(64'hF000_0000_0000_0000, 0, 64'd0, 5'd11, 1, 0, 0)});

        resetn = 1'b0; flush = 1'b0; stall = 1'b0;
        drive(tbl[0].vi);
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        resetn = 1'b1;

        foreach (tbl[i]) issue(tbl[i].name, tbl[i].vi, tbl[i].ve, exp_lat(tbl[i].vi));

        // Stall holds an ADD result for two cycles, then the held-back SUB completes.
        issue("st_add", tbl[0].vi, tbl[0].ve, 1);
        stall = 1'b1;
        drive(tbl[1].vi);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("stall.res", alu_result, 64'd12);
            chk("stall.rd", 64'(rd_out), 64'd3);
            chk("stall.we", 64'(reg_write_enable_out), 64'd1);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        chk("unstall.res", alu_result, ONES);

        flush = 1'b1;
        drive(tbl[0].vi);
        @(posedge clk); #1;
        chk_zero("flush");
        stall = 1'b1;
        drive(tbl[7].vi);
        @(posedge clk); #1;
        chk_zero("flush_stall");
        flush = 1'b0; stall = 1'b0;

        issue("rst_add", tbl[0].vi, tbl[0].ve, 1);
        resetn = 1'b0;
        #1 chk_zero("rst_async");
        drive(nop);
        @(posedge clk); #1;
        resetn = 1'b1;

`ifdef IEXECUTE_SERIAL_SHIFT_EN
        drive(sra3);
        @(posedge clk); #1;
        chk("fl.busy1", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("fl.busy2", 64'(busy), 64'd1);
        flush = 1'b1;
        drive(nop);
        @(posedge clk); #1;
        chk_zero("fl.shift");
        flush = 1'b0;

        v = mkv(7'h33, 3'd5, 7'h00, 4'd7, 64'd0, 64'd0, 64'h10, 64'd2, 5'd13, 1, 0, 0);
        drive(v);
        @(posedge clk); #1;
        chk("ss.busy0", 64'(busy), 64'd1);
        stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("ss.busy_st", 64'(busy), 64'd1);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        chk("ss.busy3", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("ss.busy4", 64'(busy), 64'd0);
        chk("ss.res", alu_result, 64'h4);
        chk("ss.rd", 64'(rd_out), 64'd13);

        drive(sra3);
        @(posedge clk); #1;
        chk("rs.busy", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1 chk_zero("rst_shift");
        drive(nop);
        @(posedge clk); #1;
        resetn = 1'b1;
`endif

        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 9);
            v.opc = (k == 9) ? 7'($urandom) : opl[k];
            v.f3  = 3'($urandom); v.f7 = 7'($urandom); v.aop = 4'($urandom);
            v.pc  = {$urandom, $urandom} & ~64'd3;
            t = $urandom;
            v.imm = ($urandom_range(0, 1) == 1) ? {{32{t[31]}}, t} : 64'($urandom_range(0, 70));
            v.rs1 = {$urandom, $urandom};
            v.rs2 = ($urandom_range(0, 3) == 0) ? v.rs1 : {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) v.rs2 = 64'($urandom_range(0, 70));
            v.rd = 5'($urandom); v.we = 1'($urandom); v.mr = 1'($urandom); v.mw = 1'($urandom);
            v.br = (v.opc == 7'h63);
            v.jp = (v.opc == 7'h6f) || (v.opc == 7'h67);
            issue($sformatf("rnd%0d", i), v, model(v), exp_lat(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iexecute.md
# iexecute

Execute stage of the RISC-V pipeline, consuming the registered control/operand bundle produced by instruction decode. Performs ALU operations, address generation, branch/jump resolution and link-value computation, then registers results into the EX/MEM pipeline register. Raises a registered redirect (`branch_taken` plus `branch_target`) that fetch/decode use as their flush. An optional serial shifter trades area for multi-cycle shifts, with a `busy` back-pressure output.

## Interface
- `XLEN`, 64: datapath width in bits; 32 or 64.
- `clk`  in  1  pipeline clock
- `resetn`  in  1  asynchronous active-low reset
- `flush`  in  1  kill the current operation; the next output is a bubble
- `stall`  in  1  downstream stall; hold all state and outputs
- `pc`  in  XLEN  PC of the instruction in EX
- `opcode`  in  7  instruction opcode
- `rd`  in  5  destination register
- `funct3`  in  3  funct3 field
- `funct7`  in  7  funct7 field
- `imm`  in  XLEN  sign-extended immediate
- `alu_op`  in  4  NOP=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 SLL=6 SRL=7 SRA=8 SLT=9 SLTU=10
- `rs1_data`, `rs2_data`  in  XLEN  register operands
- `reg_write_enable`, `mem_read`, `mem_write`, `is_branch`, `jump`  in  1  decoded controls
- `alu_result`  out  XLEN  result, memory address, or link value
- `store_data`  out  XLEN  `rs2_data`, registered
- `rd_out`  out  5  registered `rd`
- `reg_write_enable_out`, `mem_read_out`, `mem_write_out`  out  1  registered controls
- `branch_taken`  out  1  redirect request, one cycle per resolved taken branch or jump
- `branch_target`  out  XLEN  redirect address
- `busy`  out  1  a multi-cycle operation is in progress; upstream must hold its inputs

## Operation
- Operation select:
  - R-type (0110011) uses `alu_op` directly.
  - OP-IMM (0010011) derives the op from `funct3`: 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRL, or SRA when `funct7[5]`=1. Operand B is `imm`.
- Address and special results:
  - Loads and stores: `rs1_data + imm`.
  - LUI: `imm`.
  - AUIPC: `pc + imm`.
  - JAL and JALR: `pc + 4`.
- Redirects:
  - JAL (1101111) is always taken; target `pc + imm`.
  - JALR (1100111) is always taken; target `(rs1_data + imm)` with bit 0 cleared.
  - Branch (1100011) compares by `funct3`: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Target `pc + imm`.
- Arithmetic: all arithmetic is modulo 2^XLEN. SLT/SLTU return 1 or 0, zero-extended. Shift amount is operand B[5:0] when XLEN=64, [4:0] when XLEN=32.
- Unknown opcodes and `alu_op`=NOP produce result 0 and pass controls through unchanged.
- States: IDLE and SHIFT. SHIFT exists only with the macro defined.
- Priority: reset > `flush` > `stall` > normal update.

## Timing
- Reset: every output is 0, state is IDLE, `busy`=0.
- Single-cycle operations: outputs are registered, with latency 1 cycle.
- `stall`=1: all registers hold, including the shift counter. `busy` holds its value.
- `flush`=1: the next edge loads a bubble (all controls 0, `branch_taken`=0, result 0) and forces IDLE, aborting any shift in progress.
- `branch_taken` is high for exactly one cycle per taken branch or jump. It is never asserted for a bubble.
- Simultaneous `flush` and `stall`: `flush` wins.

## Configuration
- `IEXECUTE_SERIAL_SHIFT_EN` defined:
  - SLL, SRL and SRA with shift amount N>0 enter SHIFT, shifting 1 bit per unstalled cycle.
  - `busy`=1 from the cycle after issue until the cycle the result registers. Outputs are a bubble while `busy`.
  - Result appears N+1 cycles after issue.
  - N=0 completes in 1 cycle with `busy` never asserted.
- Undefined: a combinational barrel shifter is used, all shifts take 1 cycle, and `busy` is tied 0.

## Test plan
- ADD: R-type `alu_op`=1 with rs1=5, rs2=7 -> `alu_result`=12 and `reg_write_enable_out`=1 one cycle later. SUB with 0 and 1 -> all ones (0xFFFF_FFFF_FFFF_FFFF).
- Signed vs unsigned compare: rs1=−1, rs2=1. SLT -> 1; SLTU -> 0.
- BEQ taken: `pc`=0x100, `imm`=0x20, rs1=rs2 -> `branch_taken`=1 for one cycle with `branch_target`=0x120. With rs1≠rs2 -> `branch_taken`=0.
- JALR: `pc`=0x200, rs1=0x1001, `imm`=2 -> `branch_target`=0x1002 and `alu_result`=0x204.
- Serial shift (macro defined): SRA of 0x8000_0000_0000_0000 by 3 -> `busy` high for 3 cycles, then result 0xF000_0000_0000_0000. `flush` asserted in the 2nd busy cycle -> bubble output, IDLE, `busy`=0.
- Stall: `stall`=1 for 2 cycles after an ADD result -> outputs unchanged. Assert `resetn`=0 mid-shift -> all outputs 0 immediately.
